req_ack_4ph_rx: RTL
===================

// Module: req_ack_4ph_rx
// PURPOSE
//  Receive side of the 4-phase req/ack clock-domain crossing. Synchronises the incoming req into
//  clk_rx and captures the data bus, which the sender holds stable while req=1. Presents the word
//  to the consumer on a val/rdy handshake, then drives ack back to the sender. Sits directly
//  downstream of the 4-phase transmitter. req and din come from the clk_tx domain.
// PARAMETERS
//  DW           8   data width; must match the transmitter
//  SYNC_STAGES  2   flops in the req synchroniser; legal values are >= 2
// PORTS
//  clk_rx  in   1   receive-domain clock; the only clock in this block
//  rst     in   1   reset; synchronous, active-high
//  req     in   1   4-phase request from the transmitter; asynchronous to clk_rx
//  ack     out  1   4-phase acknowledge to the transmitter; registered
//  din     in   DW  data from the transmitter; stable whenever req=1
//  val     out  1   dout holds a valid word for the consumer
//  rdy     in   1   consumer accepts the word; a transfer occurs on val & rdy
//  dout    out  DW  received word; registered
//  err     out  1   sticky protocol-violation flag
// BEHAVIOUR
//  - Reset values: ack=0, val=0, dout=0, err=0, synchroniser chain=0, FSM=IDLE.
//  - req_s is req delayed through SYNC_STAGES flops. din is sampled only when req_s=1.
//  - FSM states and transitions:
//      IDLE:      when req_s=1 and val=0, next cycle dout<=din and val<=1.
//                 Then go to WAIT_CONS (default) or ACK_HI (early-ack build).
//                 If req_s=1 and val=1, stay in IDLE and do not capture.
//      WAIT_CONS: on val&rdy, next cycle val<=0, ack<=1, go to ACK_HI.
//                 If req_s=0 here, set err<=1 and stay in this state.
//      ACK_HI:    ack=1. When req_s=0, next cycle ack<=0 and go to IDLE.
//  - Latency: req rising edge -> val=1 is SYNC_STAGES+1 clk_rx edges.
//  - val, dout: once val=1, both hold stable until val&rdy. No word is dropped or duplicated.
//  - ack rises only after the word has been captured. It stays high until req_s is seen low.
//    A new capture therefore cannot occur before the previous req fall has been observed.
//  - err stays at 1 until rst. err has no effect on the data path.
//  - Reset during a handshake: all outputs return to reset values on the next edge.
//    The transmitter must be reset at the same time.
// CONFIGURATION
//  REQ_ACK_RX_EARLY_ACK_EN
//   - Defined: IDLE captures the word and goes directly to ACK_HI, so ack rises together
//     with val, independently of rdy. val clears on val&rdy from any state. The output
//     register acts as a one-word buffer. IDLE does not capture while val=1.
//     The WAIT_CONS state and the err set-condition are not built; err is tied to 0.
//   - Undefined: default behaviour, ack waits for consumer acceptance as described above.
// STRUCTURE
//  - Package req_ack_4ph_pkg holds:
//      typedef enum logic [1:0] {IDLE, WAIT_CONS, ACK_HI} rx_state_t
//      localparam int SYNC_STAGES_MIN = 2
//  - One sub-module, req_ack_sync:
//      parameterised N-flop single-bit synchroniser with synchronous reset to 0.
//  - The FSM and the data register sit in this module.
//  - An elaboration-time check rejects SYNC_STAGES < SYNC_STAGES_MIN.
// TESTING  (DW=8, SYNC_STAGES=2, behavioural 4-phase transmitter model on an unrelated clk_tx)
//  1. Reset: rst=1 for 3 cycles while req=1 -> ack=0, val=0, dout=0, err=0 throughout.
//  2. Single word: din=8'hA5, req rises, rdy=1 ->
//       val=1 with dout=A5 on the 3rd clk_rx edge after the req edge;
//       ack=1 one cycle after val&rdy; ack=0 within 3 edges of req falling.
//  3. Backpressure: rdy=0 for 10 cycles after val=1 ->
//       dout stays 8'hA5 and val stays 1;
//       ack stays 0 (default build) or is 1 (EARLY_ACK build).
//  4. Stream: 16 words 8'h00..8'h0F with random rdy ->
//       received in order, exactly once; err stays 0.
//  5. Violation (default build): drop req while in WAIT_CONS ->
//       err=1 the next cycle and still 1 after 20 cycles and a later completed transfer.
//  6. Reset mid-handshake: assert rst while in ACK_HI ->
//       ack=0 and val=0 on the next edge; a fresh transfer after reset completes correctly.

Source files
------------

// File: rtl/req_ack_4ph_pkg.sv
// Shared types and limits for the 4-phase req/ack receiver.
package req_ack_4ph_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CONS,
    ACK_HI
  } rx_state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/req_ack_sync.sv
// N-flop single-bit synchroniser, synchronous active-high reset to 0.
module req_ack_sync #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[N-2:0], i_d};
  end

  assign o_q = r_chain[N-1];

endmodule

// File: rtl/req_ack_4ph_rx.sv
// Receive side of the 4-phase req/ack crossing: sync req, capture din, val/rdy out, ack back.
// Build option REQ_ACK_RX_EARLY_ACK_EN: ack rises with val; output register becomes a one-word buffer.
module req_ack_4ph_rx
  import req_ack_4ph_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_rx,
  input  logic          rst,
  input  logic          req,
  output logic          ack,
  input  logic [DW-1:0] din,
  output logic          val,
  input  logic          rdy,
  output logic [DW-1:0] dout,
  output logic          err
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
      $error("req_ack_4ph_rx: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
    end
  endgenerate

  logic          w_req_s;
  rx_state_t     r_state;
  logic          r_ack;
  logic          r_val;
  logic [DW-1:0] r_dout;

  req_ack_sync #(.N(SYNC_STAGES)) u_sync (
    .i_clk (clk_rx),
    .i_rst (rst),
    .i_d   (req),
    .o_q   (w_req_s)
  );

`ifdef REQ_ACK_RX_EARLY_ACK_EN
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_val   <= 1'b0;
      r_dout  <= '0;
    end else begin
      // Consumer drains the buffer independently of the sender handshake.
      if (r_val && rdy) r_val <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_s && !r_val) begin
            r_dout  <= din;
            r_val   <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= ACK_HI;
          end
        end
        ACK_HI: begin
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign err = 1'b0;
`else
  logic r_err;

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_val   <= 1'b0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_s && !r_val) begin
            r_dout  <= din;
            r_val   <= 1'b1;
            r_state <= WAIT_CONS;
          end
        end
        WAIT_CONS: begin
          // Sender withdrew req before we acknowledged: protocol violation.
          if (!w_req_s) r_err <= 1'b1;
          if (r_val && rdy) begin
            r_val   <= 1'b0;
            r_ack   <= 1'b1;
            r_state <= ACK_HI;
          end
        end
        ACK_HI: begin
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign err = r_err;
`endif

  assign ack  = r_ack;
  assign val  = r_val;
  assign dout = r_dout;

endmodule
